// File: rtl/axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_arbiter
//
// Packet-atomic round-robin arbiter that shares a single stream FIFO write
// port among N_REQ upstream requesters. Once a requester is granted, the grant
// stays locked to it until its last beat is accepted. A watchdog releases the
// grant if the locked source leaves req_vld low for TIMEOUT cycles.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   clear        synchronous soft reset, same effect as rst
//   req_vld      per-requester beat valid            [N_REQ]
//   req_data     per-requester data, i at [i*WIDTH +: WIDTH]
//   req_last     per-requester last-beat flag        [N_REQ]
//   req_rdy      per-requester ready, one-hot or zero [N_REQ]
//   out_vld      beat valid to the FIFO write side
//   out_data     beat data to the FIFO               [WIDTH]
//   out_last     last flag forwarded with the beat
//   out_rdy      FIFO write ready
//   grant_id     currently granted requester (valid while busy)
//   busy         high while a grant is locked
//   pkt_done     1-cycle pulse when a last beat transfers
//   timeout_err  1-cycle pulse on watchdog release
// -----------------------------------------------------------------------------
module axis_rr_arbiter #(
  parameter int          N_REQ   = 4,
  parameter int          WIDTH   = 8,
  parameter logic [15:0] TIMEOUT = 16'd256,
  localparam int         IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic [N_REQ-1:0]       req_vld,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]       req_last,
  output logic [N_REQ-1:0]       req_rdy,
  output logic                   out_vld,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  input  logic                   out_rdy,
  output logic [IDW-1:0]         grant_id,
  output logic                   busy,
  output logic                   pkt_done,
  output logic                   timeout_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  localparam logic [IDW-1:0] LAST_ID  = IDW'(N_REQ - 1);
  localparam logic [15:0]    CNT_MAX  = 16'hFFFF;

  // Pointer to the requester after g, wrapping back to 0 past the last one.
  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] g);
    next_ptr = (g == LAST_ID) ? '0 : g + IDW'(1);
  endfunction

  state_e           state_q,    state_d;
  logic [IDW-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [IDW-1:0]   grant_q,    grant_d;
  logic [15:0]      idle_cnt_q, idle_cnt_d;

  logic             abort_s;
  logic             sel_any_s;
  logic             sel_hi_any_s;
  logic [IDW-1:0]   sel_hi_idx_s;
  logic [IDW-1:0]   sel_lo_idx_s;
  logic [IDW-1:0]   sel_idx_s;

  logic             g_vld_s;
  logic             g_last_s;
  logic [WIDTH-1:0] g_data_s;
  logic [N_REQ-1:0] g_onehot_s;

  logic             xfer_s;
  logic             wd_hit_s;

  logic [N_REQ-1:0] req_rdy_s;
  logic             out_vld_s;
  logic [WIDTH-1:0] out_data_s;
  logic             out_last_s;
  logic             pkt_done_s;
  logic             timeout_err_s;

  assign abort_s = rst | clear;

  // Round-robin pick: lowest valid index at or above rr_ptr, otherwise the
  // lowest valid index overall (the wrap-around case). The loop walks down so
  // the final assignment is the lowest matching index.
  always_comb begin
    sel_hi_any_s = 1'b0;
    sel_hi_idx_s = '0;
    sel_lo_idx_s = '0;
    sel_any_s    = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sel_hi_idx_s = (req_vld[i] && (IDW'(i) >= rr_ptr_q)) ? IDW'(i) : sel_hi_idx_s;
      sel_hi_any_s = sel_hi_any_s | (req_vld[i] && (IDW'(i) >= rr_ptr_q));
      sel_lo_idx_s = req_vld[i] ? IDW'(i) : sel_lo_idx_s;
      sel_any_s    = sel_any_s | req_vld[i];
    end
    sel_idx_s = sel_hi_any_s ? sel_hi_idx_s : sel_lo_idx_s;
  end

  // Multiplex the granted requester's stream signals from the registered grant.
  always_comb begin
    g_vld_s    = 1'b0;
    g_last_s   = 1'b0;
    g_data_s   = '0;
    g_onehot_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      g_vld_s       = (grant_q == IDW'(i)) ? req_vld[i] : g_vld_s;
      g_last_s      = (grant_q == IDW'(i)) ? req_last[i] : g_last_s;
      g_data_s      = (grant_q == IDW'(i)) ? req_data[i*WIDTH +: WIDTH] : g_data_s;
      g_onehot_s[i] = (grant_q == IDW'(i));
    end
  end

  assign xfer_s   = (state_q == ST_LOCK) && g_vld_s && out_rdy;
  // Fires on the cycle the counter has already seen TIMEOUT-1 empty cycles.
  assign wd_hit_s = (TIMEOUT != 16'd0) && (idle_cnt_q == (TIMEOUT - 16'd1)) && !g_vld_s;

  // Next-state, pointer, watchdog and datapath outputs of the IDLE/LOCK FSM.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    idle_cnt_d    = idle_cnt_q;
    req_rdy_s     = '0;
    out_vld_s     = 1'b0;
    out_data_s    = '0;
    out_last_s    = 1'b0;
    pkt_done_s    = 1'b0;
    timeout_err_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idle_cnt_d = 16'd0;
        if (sel_any_s) begin
          state_d = ST_LOCK;
          grant_d = sel_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCK: begin
        out_vld_s  = g_vld_s;
        out_data_s = g_data_s;
        out_last_s = g_last_s;
        req_rdy_s  = out_rdy ? g_onehot_s : '0;
        if (xfer_s) begin
          idle_cnt_d = 16'd0;
          if (g_last_s) begin
            pkt_done_s = 1'b1;
            state_d    = ST_IDLE;
            rr_ptr_d   = next_ptr(grant_q);
          end else begin
            state_d = ST_LOCK;
          end
        end else if (!g_vld_s) begin
          // Source bubble: counts toward the watchdog.
          if (wd_hit_s) begin
            timeout_err_s = 1'b1;
            state_d       = ST_IDLE;
            rr_ptr_d      = next_ptr(grant_q);
            idle_cnt_d    = 16'd0;
          end else begin
            idle_cnt_d = (idle_cnt_q == CNT_MAX) ? idle_cnt_q : idle_cnt_q + 16'd1;
          end
        end else begin
          // Backpressure from the FIFO: the source is alive, hold the count.
          idle_cnt_d = idle_cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A reset cycle blocks any transfer or pulse, so an aborted packet never
  // shows a partial completion.
  assign req_rdy     = abort_s ? '0 : req_rdy_s;
  assign out_vld     = abort_s ? 1'b0 : out_vld_s;
  assign out_data    = abort_s ? '0 : out_data_s;
  assign out_last    = abort_s ? 1'b0 : out_last_s;
  assign pkt_done    = abort_s ? 1'b0 : pkt_done_s;
  assign timeout_err = abort_s ? 1'b0 : timeout_err_s;

  assign grant_id = grant_q;
  assign busy     = (state_q == ST_LOCK);

  // State registers with synchronous reset and soft clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      idle_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_rr_arbiter
//
// Directed bench for axis_rr_arbiter (N_REQ=4, WIDTH=8, TIMEOUT=8). Each
// requester is a simple source that presents beat b of its packet with data
// {i, b} and raises last on beat plen[i]-1; it advances when it sees its beat
// accepted. Expected values are written per cycle from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_axis_rr_arbiter;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [3:0]  req_vld;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_rdy;
  logic        out_vld;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_rdy;
  logic [1:0]  grant_id;
  logic        busy;
  logic        pkt_done;
  logic        timeout_err;

  int          n_chk;
  int          n_pass;
  int          beat [4];
  int          plen [4];
  logic [3:0]  en;
  logic [6:0]  pat;
  int          ebeat [7];

  axis_rr_arbiter #(
    .N_REQ   (4),
    .WIDTH   (8),
    .TIMEOUT (16'd8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .req_vld     (req_vld),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_rdy     (req_rdy),
    .out_vld     (out_vld),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_rdy     (out_rdy),
    .grant_id    (grant_id),
    .busy        (busy),
    .pkt_done    (pkt_done),
    .timeout_err (timeout_err)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present every source's current beat and the enable mask, then settle.
  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      req_data[i*8 +: 8] = 8'(i * 16 + beat[i]);
      req_last[i]        = (beat[i] == plen[i] - 1);
    end
    req_vld = en;
    #1;
  endtask

  // Advance one clock; sources whose beat was accepted move to the next beat.
  task automatic tick();
    logic [3:0] acc;
    acc = req_vld & req_rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        beat[i] = (beat[i] + 1 == plen[i]) ? 0 : beat[i] + 1;
      end
    end
    apply();
  endtask

  task automatic reset_sources();
    for (int i = 0; i < 4; i++) begin
      beat[i] = 0;
    end
  endtask

  // Hard bound on simulated time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    rst     = 1'b1;
    clear   = 1'b0;
    out_rdy = 1'b1;
    en      = 4'hF;
    req_vld = 4'h0;
    req_data = 32'h0;
    req_last = 4'h0;
    for (int i = 0; i < 4; i++) begin
      beat[i] = 0;
      plen[i] = 3;
    end
    pat   = 7'b1011001;
    ebeat = '{0, 1, 1, 1, 2, 3, 3};
    apply();

    // ---------------- reset with every requester valid ----------------
    tick();
    tick();
    chk("rst_req_rdy", 32'(req_rdy), 32'h0);
    chk("rst_out_vld", 32'(out_vld), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // ---------------- round robin, 3-beat packets ----------------
    rst = 1'b0;
    apply();
    for (int k = 0; k < 20; k++) begin
      int ph;
      int g;
      if (k > 0) tick();
      ph = k % 4;
      g  = (k / 4) % 4;
      chk("rr_busy", 32'(busy), 32'(ph != 0));
      chk("rr_out_vld", 32'(out_vld), 32'(ph != 0));
      chk("rr_pkt_done", 32'(pkt_done), 32'(ph == 3));
      if (ph != 0) begin
        chk("rr_grant", 32'(grant_id), 32'(g));
        chk("rr_data", 32'(out_data), 32'(g * 16 + ph - 1));
        chk("rr_last", 32'(out_last), 32'(ph == 3));
        chk("rr_req_rdy", 32'(req_rdy), 32'(4'b0001 << g));
      end
    end

    // ---------------- atomicity under backpressure ----------------
    tick();
    en      = 4'b0100;
    plen[2] = 4;
    apply();
    chk("at_idle_busy", 32'(busy), 32'h0);
    for (int j = 0; j < 7; j++) begin
      tick();
      en      = 4'b0110;
      out_rdy = pat[j];
      apply();
      chk("at_grant", 32'(grant_id), 32'd2);
      chk("at_out_vld", 32'(out_vld), 32'd1);
      chk("at_data", 32'(out_data), 32'(8'h20 + ebeat[j]));
      chk("at_last", 32'(out_last), 32'(ebeat[j] == 3));
      chk("at_req_rdy", 32'(req_rdy), pat[j] ? 32'h4 : 32'h0);
      chk("at_pkt_done", 32'(pkt_done), 32'(j == 6));
    end
    // rr_ptr now 3: with 0 and 1 valid, 0 must win.
    tick();
    en      = 4'b0011;
    out_rdy = 1'b1;
    plen[0] = 1;
    apply();
    chk("at_gap_busy", 32'(busy), 32'h0);
    chk("at_gap_vld", 32'(out_vld), 32'h0);
    chk("at_gap_rdy", 32'(req_rdy), 32'h0);
    tick();
    chk("at_next_grant", 32'(grant_id), 32'd0);
    chk("at_next_busy", 32'(busy), 32'd1);
    chk("at_next_last", 32'(out_last), 32'd1);
    chk("at_next_done", 32'(pkt_done), 32'd1);

    // ---------------- watchdog ----------------
    tick();
    en      = 4'b0010;
    plen[1] = 4;
    apply();
    tick();
    chk("wd_grant", 32'(grant_id), 32'd1);
    chk("wd_data", 32'(out_data), 32'h10);
    chk("wd_last", 32'(out_last), 32'd0);
    chk("wd_done", 32'(pkt_done), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      en = 4'b0100;
      apply();
      chk("wd_busy", 32'(busy), 32'd1);
      chk("wd_req_rdy", 32'(req_rdy), 32'h2);
      chk("wd_err", 32'(timeout_err), 32'(k == 8));
    end
    tick();
    chk("wd_rel_busy", 32'(busy), 32'd0);
    chk("wd_rel_err", 32'(timeout_err), 32'd0);
    for (int b = 0; b < 4; b++) begin
      tick();
      chk("wd_next_grant", 32'(grant_id), 32'd2);
      chk("wd_next_data", 32'(out_data), 32'(8'h20 + b));
      chk("wd_next_done", 32'(pkt_done), 32'(b == 3));
    end

    // ---------------- clear mid-packet ----------------
    tick();
    en      = 4'b1000;
    plen[3] = 5;
    apply();
    chk("cl_idle_busy", 32'(busy), 32'd0);
    tick();
    chk("cl_grant", 32'(grant_id), 32'd3);
    chk("cl_data0", 32'(out_data), 32'h30);
    tick();
    clear = 1'b1;
    apply();
    chk("cl_pulse_done", 32'(pkt_done), 32'd0);
    tick();
    clear = 1'b0;
    en    = 4'b1110;
    reset_sources();
    apply();
    chk("cl_out_vld", 32'(out_vld), 32'd0);
    chk("cl_busy", 32'(busy), 32'd0);
    chk("cl_done", 32'(pkt_done), 32'd0);
    chk("cl_req_rdy", 32'(req_rdy), 32'h0);
    tick();
    // rr_ptr back at 0, so requester 1 beats 2 and 3.
    chk("cl_rr_grant", 32'(grant_id), 32'd1);
    chk("cl_rr_busy", 32'(busy), 32'd1);
    tick();
    clear = 1'b1;
    en    = 4'b0000;
    apply();
    tick();
    clear = 1'b0;
    reset_sources();
    apply();

    // ---------------- single-beat packets, pointer wrap ----------------
    en      = 4'b1000;
    plen[3] = 1;
    apply();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      chk("sb_busy", 32'(busy), 32'(k % 2));
      chk("sb_out_vld", 32'(out_vld), 32'(k % 2));
      chk("sb_done", 32'(pkt_done), 32'(k % 2));
      if ((k % 2) == 1) begin
        chk("sb_grant", 32'(grant_id), 32'd3);
        chk("sb_last", 32'(out_last), 32'd1);
        chk("sb_data", 32'(out_data), 32'h30);
      end
    end
    tick();
    en = 4'b1001;
    apply();
    chk("sb_gap_busy", 32'(busy), 32'd0);
    tick();
    chk("sb_wrap_grant", 32'(grant_id), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares one stream FIFO write port among N_REQ upstream requesters.
- Each requester presents a valid/ready/data/last stream. The arbiter locks the grant to one requester until its last beat is accepted.
- Sits in front of the axis FIFO feeding axis_master. A watchdog releases a grant whose source stalls mid-packet.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, data width per beat
TIMEOUT, 16'd256, cycles of source-invalid while locked before forced release; 0 disables the watchdog

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
clear  input  1  synchronous soft reset, same effect as rst
req_vld  input  N_REQ  per-requester beat valid
req_data  input  N_REQ*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH]
req_last  input  N_REQ  per-requester last-beat flag
req_rdy  output  N_REQ  per-requester ready
out_vld  output  1  beat valid to the FIFO write side
out_data  output  WIDTH  beat data to the FIFO
out_last  output  1  last flag forwarded with the beat
out_rdy  input  1  FIFO write ready
grant_id  output  $clog2(N_REQ)  currently granted requester
busy  output  1  high in LOCK
pkt_done  output  1  1-cycle pulse when a last beat transfers
timeout_err  output  1  1-cycle pulse on watchdog release

Behaviour:
- rst or clear, sampled on a clk edge, forces:
  - state=IDLE, rr_ptr=0, grant_id=0, idle_cnt=0.
  - req_rdy, out_vld, out_last, busy, pkt_done, timeout_err all 0; out_data=0.
  - rst and clear take priority over all other activity, including mid-packet. No last beat is synthesized on abort.
- States: IDLE, LOCK.
- IDLE:
  - req_rdy=0, out_vld=0, out_data=0.
  - If any req_vld is set, select the first set index searching rr_ptr, rr_ptr+1, ..., wrapping modulo N_REQ.
  - Register that index into grant_id and go to LOCK on the next edge.
  - Latency: 1 cycle from req_vld high to the first possible transfer.
- LOCK, with g=grant_id:
  - out_vld=req_vld[g], out_data=req_data[g], out_last=req_last[g], all combinational from the registered g.
  - req_rdy[g]=out_rdy; every other req_rdy bit is 0.
  - Transfer occurs on out_vld && out_rdy.
  - Grant is held regardless of other requesters' req_vld. Bubbles (req_vld[g]=0) are allowed mid-packet.
  - Backpressure (out_vld=1, out_rdy=0) is unbounded and does not advance the watchdog.
- Packet end: a transfer with out_last=1 causes:
  - pkt_done=1 in the same cycle (combinational with the transfer);
  - next state IDLE;
  - rr_ptr <= (g==N_REQ-1) ? 0 : g+1.
  - There is always one IDLE cycle between packets. Back-to-back packets from requesters are therefore separated by at least 1 cycle.
- Watchdog (active only if TIMEOUT!=0, LOCK state only):
  - idle_cnt (16-bit) increments each LOCK cycle with req_vld[g]=0.
  - idle_cnt clears on any transfer and on entering IDLE.
  - When idle_cnt==TIMEOUT-1 and req_vld[g] is still 0: timeout_err pulses 1 cycle, next state IDLE, rr_ptr advances as for packet end.
  - idle_cnt saturates and does not wrap.
- Single-beat packet (req_last=1 on the first beat) is legal: LOCK lasts until that beat transfers.
- A requester that drops req_vld while in IDLE after being observed is still granted; the watchdog handles abandonment.
- grant_id holds its last value in IDLE; it is valid only while busy=1.
- N_REQ=1 degenerates to pass-through with a 1-cycle IDLE between packets.
- Invariant: req_rdy is one-hot or zero.

Test Plan:
- Reset: drive rst for 2 cycles with all req_vld=1 -> req_rdy=0, out_vld=0, grant_id=0, busy=0. The first grant after release goes to requester 0.
- Round robin: all 4 requesters continuously send 3-beat packets with out_rdy=1 -> grant order 0,1,2,3,0 with pkt_done pulses at cycles 4,8,12,16. Each packet is 1 IDLE cycle plus 3 beats.
- Atomicity under backpressure: requester 2 sends a 4-beat packet; out_rdy is toggled 1,0,0,1,... while requester 1 is also valid -> all 4 beats from requester 2 are contiguous on out_*, req_rdy[1]=0 throughout, and the next grant goes to 3 if valid, else 0, else 1.
- Watchdog: TIMEOUT=8; requester 1 sends 1 beat without last, then drops req_vld -> timeout_err pulses exactly 8 cycles after the last transfer, busy falls, and the next grant goes to requester 2.
- Clear mid-packet: assert clear on the 2nd beat of a 5-beat packet from requester 3 -> the next cycle shows out_vld=0, busy=0, rr_ptr=0, and no pkt_done.
- Wrap and single-beat: only requester 3 is valid, sending single-beat packets -> a grant every 2 cycles, rr_ptr wraps 3->0, and out_last=1 on every beat.
